omsp_spm_cmd_seq: RTL and testbench

Command sequencer in front of the protected-module (SPM) control array.
- Accepts one protect / unprotect / verify command at a time from the execution unit.
- Drives the update/enable/verify strobes into the SPM control, then samples its violation or verify result.
- For protect, fetches the module key from the key-derivation (KDF) engine and writes it word by word into the new SPM's key storage.
- Reports completion with a one-cycle done pulse and a status code.

---
 rtl/omsp_spm_cmd_seq.sv | 207 ++++++++++++++++++++
 tb/tb_omsp_spm_cmd_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/omsp_spm_cmd_seq.sv
// SPM command sequencer: runs protect / unprotect / verify commands against the
// SPM control array and streams the KDF-derived module key into key storage.
module omsp_spm_cmd_seq #(
    parameter int unsigned KEY_IDX_SIZE = 2,
    parameter int unsigned KEY_WORDS    = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                    mclk,
    input  logic                    puc_rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic                    sm_executing,
    input  logic                    spm_violation,
    input  logic                    verify_match,
    output logic                    update_spm,
    output logic                    enable_spm,
    output logic                    verify_spm,
    output logic                    kdf_req,
    input  logic                    kdf_ack,
    input  logic                    kdf_word_valid,
    input  logic [15:0]             kdf_word,
    output logic                    write_key,
    output logic [15:0]             key_in,
    output logic [KEY_IDX_SIZE-1:0] key_idx,
    output logic                    busy,
    output logic                    done,
    output logic [2:0]              status
);

    localparam int unsigned TMO_W = 8;
    localparam int unsigned CNT_W = KEY_IDX_SIZE + 1;

    localparam logic [1:0] OP_PROTECT   = 2'b00;
    localparam logic [1:0] OP_UNPROTECT = 2'b01;
    localparam logic [1:0] OP_VERIFY    = 2'b10;

    localparam logic [2:0] ST_OK          = 3'b000;
    localparam logic [2:0] ST_VIOLATION   = 3'b001;
    localparam logic [2:0] ST_DENIED      = 3'b010;
    localparam logic [2:0] ST_VERIFY_FAIL = 3'b011;
    localparam logic [2:0] ST_TIMEOUT     = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UPDATE,
        S_CHECK,
        S_KDF_REQ,
        S_KEY_WR,
        S_VERIFY,
        S_VCHECK,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [2:0]              status_q, status_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [TMO_W-1:0]        tmo_inc;
    logic                    tmo_hit;
    logic [KEY_IDX_SIZE-1:0] key_idx_q, key_idx_d;
    logic [CNT_W-1:0]        wcnt_q, wcnt_d;
    logic [15:0]             key_in_q, key_in_d;
    logic                    write_key_q, write_key_d;
    logic                    last_write;

    assign tmo_inc    = tmo_q + TMO_W'(1);
    assign tmo_hit    = (tmo_inc == TMO_W'(TIMEOUT));
    assign last_write = write_key_q && (key_idx_q == KEY_IDX_SIZE'(KEY_WORDS - 1));

    // State register and datapath registers
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            status_q    <= ST_OK;
            tmo_q       <= '0;
            key_idx_q   <= '0;
            wcnt_q      <= '0;
            key_in_q    <= 16'h0000;
            write_key_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            status_q    <= status_d;
            tmo_q       <= tmo_d;
            key_idx_q   <= key_idx_d;
            wcnt_q      <= wcnt_d;
            key_in_q    <= key_in_d;
            write_key_q <= write_key_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        status_d    = status_q;
        tmo_d       = tmo_q;
        key_idx_d   = key_idx_q;
        wcnt_d      = wcnt_q;
        key_in_d    = key_in_q;
        write_key_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d = cmd_op;
                    unique case (cmd_op)
                        OP_PROTECT: state_d = S_UPDATE;
                        OP_UNPROTECT: begin
                            if (sm_executing) begin
                                state_d = S_UPDATE;
                            end else begin
                                state_d  = S_DONE;
                                status_d = ST_DENIED;
                            end
                        end
                        OP_VERIFY: state_d = S_VERIFY;
                        default: begin
                            state_d  = S_DONE;
                            status_d = ST_DENIED;
                        end
                    endcase
                end
            end

            S_UPDATE: state_d = S_CHECK;

            S_CHECK: begin
                if (spm_violation) begin
                    state_d  = S_DONE;
                    status_d = ST_VIOLATION;
                end else if (op_q == OP_UNPROTECT) begin
                    state_d  = S_DONE;
                    status_d = ST_OK;
                end else begin
                    state_d   = S_KDF_REQ;
                    tmo_d     = '0;
                    key_idx_d = '0;
                    wcnt_d    = '0;
                end
            end

            // A word presented together with the ack is deliberately dropped
            S_KDF_REQ: begin
                if (kdf_ack) begin
                    state_d = S_KEY_WR;
                    tmo_d   = '0;
                end else if (tmo_hit) begin
                    state_d  = S_DONE;
                    status_d = ST_TIMEOUT;
                end else begin
                    tmo_d = tmo_inc;
                end
            end

            // Capture a word, then strobe it one cycle later with the index it belongs to
            S_KEY_WR: begin
                if (kdf_word_valid && (wcnt_q < CNT_W'(KEY_WORDS))) begin
                    key_in_d    = kdf_word;
                    write_key_d = 1'b1;
                    wcnt_d      = wcnt_q + CNT_W'(1);
                end
                if (write_key_q) begin
                    key_idx_d = key_idx_q + KEY_IDX_SIZE'(1);
                end
                if (last_write) begin
                    state_d  = S_DONE;
                    status_d = ST_OK;
                end else if (kdf_word_valid) begin
                    tmo_d = '0;
                end else if (tmo_hit) begin
                    state_d  = S_DONE;
                    status_d = ST_TIMEOUT;
                end else begin
                    tmo_d = tmo_inc;
                end
            end

            S_VERIFY: state_d = S_VCHECK;

            S_VCHECK: begin
                state_d  = S_DONE;
                status_d = verify_match ? ST_OK : ST_VERIFY_FAIL;
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // Strobes decode directly from the state register
    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign update_spm = (state_q == S_UPDATE);
    assign enable_spm = (state_q == S_UPDATE) && (op_q == OP_PROTECT);
    assign verify_spm = (state_q == S_VERIFY);
    assign kdf_req    = (state_q == S_KDF_REQ);
    assign done       = (state_q == S_DONE);
    assign write_key  = write_key_q;
    assign key_in     = key_in_q;
    assign key_idx    = key_idx_q;
    assign status     = status_q;

endmodule

// File: tb/tb_omsp_spm_cmd_seq.sv
// Directed bench for omsp_spm_cmd_seq: a timeline model predicts every output
// each cycle of a command; per-command literal counts pin the model itself.
module tb_omsp_spm_cmd_seq;

    localparam int unsigned KIS = 2;
    localparam int unsigned KW  = 4;
    localparam int          TO  = 255;

    logic           mclk;
    logic           puc_rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic           sm_executing;
    logic           spm_violation;
    logic           verify_match;
    logic           update_spm;
    logic           enable_spm;
    logic           verify_spm;
    logic           kdf_req;
    logic           kdf_ack;
    logic           kdf_word_valid;
    logic [15:0]    kdf_word;
    logic           write_key;
    logic [15:0]    key_in;
    logic [KIS-1:0] key_idx;
    logic           busy;
    logic           done;
    logic [2:0]     status;

    omsp_spm_cmd_seq #(.KEY_IDX_SIZE(KIS), .KEY_WORDS(KW), .TIMEOUT(TO)) dut (
        .mclk(mclk), .puc_rst(puc_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .sm_executing(sm_executing), .spm_violation(spm_violation),
        .verify_match(verify_match), .update_spm(update_spm), .enable_spm(enable_spm),
        .verify_spm(verify_spm), .kdf_req(kdf_req), .kdf_ack(kdf_ack),
        .kdf_word_valid(kdf_word_valid), .kdf_word(kdf_word), .write_key(write_key),
        .key_in(key_in), .key_idx(key_idx), .busy(busy), .done(done), .status(status)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_kreq = 0;
    int cnt_wk   = 0;
    int cnt_done = 0;
    int cur_c    = 0;
    bit cmp_en   = 1'b0;

    // Model state carried across commands
    logic [2:0]     m_status;
    logic [15:0]    m_key_in;
    logic [KIS-1:0] m_key_idx;
    bit e_rdy, e_busy, e_upd, e_en, e_ver, e_kreq, e_wk, e_done;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    function automatic logic [15:0] word(input logic [15:0] base, input int i);
        return base + 16'(i) * 16'h1111;
    endfunction

    task automatic set_idle_exp();
        e_rdy = 1'b1; e_busy = 1'b0; e_upd = 1'b0; e_en = 1'b0;
        e_ver = 1'b0; e_kreq = 1'b0; e_wk = 1'b0; e_done = 1'b0;
    endtask

    task automatic clear_inputs();
        cmd_valid = 1'b0; cmd_op = 2'b00; sm_executing = 1'b0; spm_violation = 1'b0;
        verify_match = 1'b0; kdf_ack = 1'b0; kdf_word_valid = 1'b0; kdf_word = 16'h0000;
    endtask

    // Compare every output against the model on the falling edge
    always @(negedge mclk) begin
        if (cmp_en) begin
            chk("cmd_ready",  cur_c, 32'(cmd_ready),  32'(e_rdy));
            chk("busy",       cur_c, 32'(busy),       32'(e_busy));
            chk("update_spm", cur_c, 32'(update_spm), 32'(e_upd));
            if (e_upd) chk("enable_spm", cur_c, 32'(enable_spm), 32'(e_en));
            chk("verify_spm", cur_c, 32'(verify_spm), 32'(e_ver));
            chk("kdf_req",    cur_c, 32'(kdf_req),    32'(e_kreq));
            chk("write_key",  cur_c, 32'(write_key),  32'(e_wk));
            chk("done",       cur_c, 32'(done),       32'(e_done));
            chk("key_in",     cur_c, 32'(key_in),     32'(m_key_in));
            chk("key_idx",    cur_c, 32'(key_idx),    32'(m_key_idx));
            chk("status",     cur_c, 32'(status),     32'(m_status));
            if (kdf_req)   cnt_kreq++;
            if (write_key) cnt_wk++;
            if (done)      cnt_done++;
        end
    end

    // One command: cycle 0 is the accept cycle; ack_at < 0 means the KDF never acks
    task automatic run_scn(input int op, input int sm, input int viol, input int ack_at,
                           input int nw, input int vm, input int rst_at, input logic [15:0] base,
                           input int lit_kreq, input int lit_wk, input int lit_done,
                           input logic [2:0] lit_st);
        bit         prot_path, upd_path, has_ack, prev_wk;
        int         done_c, k_ack, last_c, kr0, wk0, dn0;
        logic [2:0] st_new;

        prot_path = (op == 0) && (viol == 0);
        upd_path  = (op == 0) || (op == 1 && sm != 0);
        has_ack   = prot_path && (ack_at >= 0);
        k_ack     = 3 + ack_at;
        if (op == 3 || (op == 1 && sm == 0)) begin done_c = 1; st_new = 3'd2; end
        else if (op == 2)                    begin done_c = 3; st_new = (vm != 0) ? 3'd0 : 3'd3; end
        else if (viol != 0)                  begin done_c = 3; st_new = 3'd1; end
        else if (op == 1)                    begin done_c = 3; st_new = 3'd0; end
        else if (!has_ack)                   begin done_c = 3 + TO; st_new = 3'd4; end
        else if (nw >= int'(KW))             begin done_c = k_ack + int'(KW) + 2; st_new = 3'd0; end
        else                                 begin done_c = k_ack + nw + TO + 1; st_new = 3'd4; end
        last_c  = (rst_at >= 0) ? rst_at : done_c + 1;
        kr0 = cnt_kreq; wk0 = cnt_wk; dn0 = cnt_done;
        prev_wk = 1'b0;

        for (int c = 0; c <= last_c; c++) begin
            @(posedge mclk); #1;
            cur_c          = c;
            cmd_valid      = (c == 0);
            cmd_op         = 2'(op);
            sm_executing   = (sm != 0);
            spm_violation  = (c == 2) ? (viol != 0) : 1'b1;
            verify_match   = (c == 2) ? (vm != 0) : (vm == 0);
            kdf_ack        = has_ack && (c == k_ack);
            kdf_word_valid = (c == 1) || (has_ack && c >= k_ack && c <= k_ack + nw);
            kdf_word       = (has_ack && c > k_ack && c <= k_ack + nw) ? word(base, c - k_ack - 1) : 16'hDEAD;
            if (c == rst_at) begin
                puc_rst   = 1'b1;
                m_status  = 3'd0;
                m_key_in  = 16'h0000;
                m_key_idx = '0;
                set_idle_exp();
            end else begin
                e_busy = (c >= 1) && (c <= done_c);
                e_rdy  = !e_busy;
                e_upd  = upd_path && (c == 1);
                e_en   = e_upd && (op == 0);
                e_ver  = (op == 2) && (c == 1);
                e_kreq = prot_path && (c >= 3) && (has_ack ? (c <= k_ack) : (c < done_c));
                e_wk   = has_ack && (c >= k_ack + 2) && (c <= k_ack + nw + 1);
                e_done = (c == done_c);
                if (prev_wk) m_key_idx = m_key_idx + KIS'(1);
                if (prot_path && c == 3) m_key_idx = '0;
                if (e_wk) m_key_in = word(base, c - k_ack - 2);
                if (c == done_c) m_status = st_new;
                prev_wk = e_wk;
            end
        end

        if (rst_at >= 0) begin
            for (int c = 1; c <= 3; c++) begin
                @(posedge mclk); #1;
                cur_c   = rst_at + c;
                puc_rst = 1'b0;
                clear_inputs();
                set_idle_exp();
            end
        end

        @(negedge mclk); #1;
        chk("kdf_req_cycles", -1, 32'(cnt_kreq - kr0), 32'(lit_kreq));
        chk("write_key_count", -1, 32'(cnt_wk - wk0), 32'(lit_wk));
        chk("done_count", -1, 32'(cnt_done - dn0), 32'(lit_done));
        chk("final_status", -1, 32'(status), 32'(lit_st));
    endtask

    initial begin
        puc_rst   = 1'b1;
        clear_inputs();
        m_status  = 3'd0;
        m_key_in  = 16'h0000;
        m_key_idx = '0;
        set_idle_exp();
        cmp_en    = 1'b1;
        repeat (2) @(posedge mclk);
        #1 puc_rst = 1'b0;

        //       op sm vl ack nw vm rst base      kreq  wk  dn  status
        run_scn(0, 0, 0,  0, 4, 0, -1, 16'h1111,   1,   4,  1, 3'd0);
        chk("key_in_last_word", -1, 32'(key_in), 32'h4444);
        run_scn(0, 0, 1,  0, 4, 0, -1, 16'h1111,   0,   0,  1, 3'd1);
        run_scn(1, 0, 0, -1, 0, 0, -1, 16'h1111,   0,   0,  1, 3'd2);
        run_scn(1, 1, 0, -1, 0, 0, -1, 16'h1111,   0,   0,  1, 3'd0);
        run_scn(2, 0, 0, -1, 0, 0, -1, 16'h1111,   0,   0,  1, 3'd3);
        run_scn(2, 0, 0, -1, 0, 1, -1, 16'h1111,   0,   0,  1, 3'd0);
        run_scn(3, 1, 0, -1, 0, 0, -1, 16'h1111,   0,   0,  1, 3'd2);
        run_scn(0, 0, 0, -1, 0, 0, -1, 16'h1111, 255,   0,  1, 3'd4);
        run_scn(0, 0, 0,  2, 2, 0, -1, 16'h1111,   3,   2,  1, 3'd4);
        chk("key_idx_after_partial", -1, 32'(key_idx), 32'd2);
        run_scn(0, 0, 0,  0, 2, 0,  7, 16'h1111,   1,   2,  0, 3'd0);
        run_scn(0, 0, 0,  1, 4, 0, -1, 16'h0A0A,   2,   4,  1, 3'd0);
        chk("key_in_after_reset_protect", -1, 32'(key_in), 32'h3D3D);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
